// File: rtl/delay_argmax_scanner.sv
// delay_argmax_scanner: per-guess delay accumulator with sequential argmax scan; DELAY_ARGMAX_SECOND_EN adds second-best margin
module delay_argmax_scanner #(
    parameter int         DELAY_W  = 24,
    parameter int         ACC_W    = 32,
    parameter logic [7:0] RANGE_LO = 8'h06,
    parameter logic [7:0] RANGE_HI = 8'hFF
) (
    input  logic               CLK_50,
    input  logic [0:0]         SW,
    input  logic               clear,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic [7:0]         sample_guess,
    input  logic [DELAY_W-1:0] sample_delay,
    input  logic               scan_start,
    output logic               scan_busy,
    output logic               result_valid,
    output logic [7:0]         result_byte,
    output logic [ACC_W-1:0]   result_delay,
    output logic [ACC_W-1:0]   result_margin
);
    typedef enum logic [2:0] {CLEAR, IDLE, ACC_RD, ACC_WR, SCAN, SCAN_FLUSH} state_t;
    state_t state_q, state_d;
    logic [7:0] clr_idx_q, clr_idx_d, scan_idx_q, scan_idx_d, cmp_idx_q, cmp_idx_d;
    logic [7:0] guess_q, guess_d, best_byte_q, best_byte_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [ACC_W-1:0] best_q, best_d, sum_q, sum_d, rd_data_q, wd;
    logic [ACC_W:0] sum_w;
    logic pend_q, pend_d, valid_q, valid_d;
    logic rst, acc, scan_go, in_range, hit, we;
    logic [7:0] wa, ra;
    logic [ACC_W-1:0] mem [256];
    assign rst = SW[0];
    assign sample_ready = state_q == IDLE && !clear;
    assign scan_busy = state_q == CLEAR || state_q == SCAN || state_q == SCAN_FLUSH;
    assign acc = sample_valid && sample_ready;
    assign scan_go = state_q == IDLE && scan_start && !acc;
    assign in_range = {1'b0, guess_q} >= {1'b0, RANGE_LO} && {1'b0, guess_q} <= {1'b0, RANGE_HI};
    assign hit = pend_q && rd_data_q > best_q;
    assign we = !clear && (state_q == CLEAR || (state_q == ACC_WR && in_range));
    assign wa = state_q == CLEAR ? clr_idx_q : guess_q;
    assign wd = state_q == CLEAR ? '0 : sum_q;
    assign ra = state_q == IDLE ? sample_guess : scan_idx_q;
    assign result_valid = valid_q;
    assign result_byte = best_byte_q;
    assign result_delay = best_q;
    // accumulator RAM: one write port, one registered read port
    always_ff @(posedge CLK_50) begin
        if (we) mem[wa] <= wd;
        rd_data_q <= mem[ra];
    end
    // next-state: clear sweep, read-modify-write of one sample, argmax scan; clear overrides everything
    always_comb begin
        state_d = state_q;
        clr_idx_d = clr_idx_q;
        scan_idx_d = scan_idx_q;
        guess_d = guess_q;
        delay_d = delay_q;
        sum_d = sum_q;
        best_d = best_q;
        best_byte_d = best_byte_q;
        valid_d = valid_q;
        sum_w = {1'b0, rd_data_q} + (ACC_W+1)'(delay_q);
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 8'd1;
                state_d = clr_idx_q == 8'hFF ? IDLE : CLEAR;
            end
            IDLE: begin
                if (acc) begin
                    guess_d = sample_guess;
                    delay_d = sample_delay;
                    valid_d = 1'b0;
                    state_d = ACC_RD;
                end else if (scan_go) begin
                    scan_idx_d = RANGE_LO;
                    best_byte_d = RANGE_LO;
                    best_d = '0;
                    valid_d = 1'b0;
                    state_d = SCAN;
                end
            end
            ACC_RD: begin
                sum_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
                state_d = ACC_WR;
            end
            ACC_WR: state_d = IDLE;
            SCAN: begin
                scan_idx_d = scan_idx_q + 8'd1;
                state_d = scan_idx_q == RANGE_HI ? SCAN_FLUSH : SCAN;
            end
            SCAN_FLUSH: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
        if (hit) begin
            best_d = rd_data_q;
            best_byte_d = cmp_idx_q;
        end
        pend_d = state_q == SCAN;
        cmp_idx_d = scan_idx_q;
        if (clear) begin
            state_d = CLEAR;
            clr_idx_d = 8'd0;
            valid_d = 1'b0;
            pend_d = 1'b0;
        end
    end
    // state and datapath registers
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_idx_q <= 8'd0;
            scan_idx_q <= RANGE_LO;
            cmp_idx_q <= 8'd0;
            guess_q <= 8'd0;
            delay_q <= '0;
            sum_q <= '0;
            best_q <= '0;
            best_byte_q <= RANGE_LO;
            pend_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
            scan_idx_q <= scan_idx_d;
            cmp_idx_q <= cmp_idx_d;
            guess_q <= guess_d;
            delay_q <= delay_d;
            sum_q <= sum_d;
            best_q <= best_d;
            best_byte_q <= best_byte_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
        end
    end
`ifdef DELAY_ARGMAX_SECOND_EN
    logic [ACC_W-1:0] second_q, second_d;
    // second-best takes the displaced best, or any value above it that is not a new best
    always_comb begin
        second_d = second_q;
        if (scan_go) second_d = '0;
        else if (hit) second_d = best_q;
        else if (pend_q && rd_data_q > second_q) second_d = rd_data_q;
    end
    // second-best register
    always_ff @(posedge CLK_50) begin
        second_q <= rst ? '0 : second_d;
    end
    assign result_margin = best_q - second_q;
`else
    assign result_margin = '0;
`endif
endmodule

// File: doc/delay_argmax_scanner.md
Name: delay_argmax_scanner

Overview:
- Consumes per-guess delay measurements from the guess-sequencing FSM: one sample = (guess byte, delay count) after each MCU reply.
- Accumulates delays per guess value over any number of trials.
- On request, scans the guess range sequentially, one entry per clock, and reports the byte with the largest accumulated delay.
- Replaces the single-cycle 256-way max search; the FSM loads the result into its correct-bytes register.

Parameters:
- DELAY_W, 24, width of incoming delay samples.
- ACC_W, 32, accumulator width per guess value; must be >= DELAY_W.
- RANGE_LO, 8'h06, first guess value scanned; equals the protocol's first guess byte.
- RANGE_HI, 8'hFF, last guess value scanned; RANGE_LO <= RANGE_HI.

Ports:
- CLK_50  in  1  system clock; single clock domain.
- SW  in  1 ([0:0])  reset, synchronous, active-high (SW[0]).
- clear  in  1  pulse: zero all accumulators and drop result (start of a new code byte).
- sample_valid  in  1  sample present.
- sample_ready  out  1  sample accepted when sample_valid && sample_ready.
- sample_guess  in  8  guess value the delay belongs to.
- sample_delay  in  DELAY_W  measured delay.
- scan_start  in  1  pulse: begin argmax scan.
- scan_busy  out  1  high while clearing or scanning.
- result_valid  out  1  result fields valid.
- result_byte  out  8  guess with the maximum accumulator.
- result_delay  out  ACC_W  that maximum.
- result_margin  out  ACC_W  maximum minus second-largest.

Behaviour:
- Storage: 256 x ACC_W accumulator RAM, one read and one write port, synchronous read (1-cycle latency).
- States: CLEAR, IDLE, ACC_RD, ACC_WR, SCAN, SCAN_FLUSH.
- Reset (SW=1): state = CLEAR, clear index = 0.
- Outputs during reset: sample_ready=0, scan_busy=1, result_valid=0, result_byte=RANGE_LO, result_delay=0, result_margin=0.
- CLEAR: writes 0 to one address per cycle for addresses 0..255, so 256 cycles. Then IDLE.
  - scan_busy=1 and sample_ready=0 throughout.
  - Entered from reset or from clear in any state; clear restarts the sweep at address 0.
- IDLE: sample_ready=1, scan_busy=0.
  - Accepted sample: latch it, read its accumulator, go to ACC_RD.
  - scan_start with no sample in the same cycle: go to SCAN.
  - sample_valid and scan_start in the same cycle: the sample wins and scan_start is dropped.
- ACC_RD -> ACC_WR: write accumulator + zero-extended sample_delay, saturating at all-ones. Return to IDLE.
  - sample_ready=0 in ACC_RD and ACC_WR, so at most one sample per 3 cycles.
  - A sample whose guess is outside RANGE_LO..RANGE_HI is accepted but discarded: no RAM write, same 3-cycle timing.
- SCAN: issues reads for RANGE_LO..RANGE_HI, one per cycle. SCAN_FLUSH absorbs the last read.
  - Comparison uses strict >, so on ties the lowest guess value wins.
  - Tracks best and second-best values.
  - result_valid rises exactly (RANGE_HI-RANGE_LO+1)+2 cycles after the scan_start cycle; for the defaults that is 252 cycles. State then returns to IDLE.
- If every accumulator is 0: result_byte=RANGE_LO, result_delay=0, result_margin=0, result_valid=1.
- result_valid and the result fields hold until the next accepted sample, scan_start, clear or reset; result_valid falls on that cycle.
- clear mid-scan or mid-RMW: abort with no partial write committed after the clear cycle; result_valid=0 next cycle.
- scan_start outside IDLE: ignored, with no queuing.
- A sample offered while sample_ready=0 must be held by the producer; the block never drops it.

Optional Feature:
- Macro: DELAY_ARGMAX_SECOND_EN.
- Defined: second-best tracking present; result_margin is as specified above.
- Undefined: no second-best logic; result_margin is constant 0. All other behaviour and timing are identical.

Test Plan:
- Reset, then observe: scan_busy=1 for 256 cycles, then sample_ready=1; scan_start immediately -> after 252 cycles result_valid=1, result_byte=8'h06, result_delay=0.
- Samples (8'h41,100), (8'h41,50), (8'h20,120), then scan -> result_byte=8'h41, result_delay=150, result_margin=30 (0 if macro undefined).
- Samples (8'h30,77) and (8'h90,77), scan -> result_byte=8'h30 (tie goes to the lower value).
- sample_delay=24'hFFFFFF applied 300 times to 8'h07 with ACC_W=32 -> accumulator 0x12BFFFED4, saturates to 32'hFFFFFFFF; scan reports that value.
- Sample (8'h03,999), then (8'h10,5), then scan -> result_byte=8'h10; sample_ready low for exactly 2 cycles after each accept.
- clear pulsed 100 cycles into a scan -> result_valid stays 0, scan_busy=1 for 256 cycles; a subsequent scan reports byte 8'h06, delay 0.
